// File: rtl/ate_pkg.sv
// Shared sizing, read-FSM states and block-order address helper for the
// adaptive threshold engine's block reorder front end.
package ate_pkg;

    localparam int unsigned PIX_W        = 8;
    localparam int unsigned IMG_W        = 48;
    localparam int unsigned IMG_H        = 32;
    localparam int unsigned BLK          = 8;
    localparam int unsigned BLK_PIX      = BLK * BLK;
    localparam int unsigned BLKS_PER_ROW = IMG_W / BLK;
    localparam int unsigned BLK_ROWS     = IMG_H / BLK;
    localparam int unsigned BANK_WORDS   = BLK * IMG_W;

    localparam int unsigned ADDR_W = $clog2(BANK_WORDS);
    localparam int unsigned BLK_W  = $clog2(BLKS_PER_ROW);
    localparam int unsigned RC_W   = $clog2(BLK);
    localparam int unsigned BROW_W = $clog2(BLK_ROWS);

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_e;

    // Word address of pixel (r,c) of block b inside a bank holding BLK image rows.
    function automatic logic [ADDR_W-1:0] blk_addr(input logic [BLK_W-1:0] b,
                                                   input logic [RC_W-1:0]  r,
                                                   input logic [RC_W-1:0]  c);
        return ADDR_W'(32'(r) * IMG_W + 32'(b) * BLK + 32'(c));
    endfunction

endpackage

// File: rtl/ate_bank_ram.sv
// Two-bank pixel store: one synchronous write port, one registered read port.
module ate_bank_ram
    import ate_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic              rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [PIX_W-1:0]  rd_data
);

    logic [PIX_W-1:0] mem_q [2][BANK_WORDS];
    logic [PIX_W-1:0] rd_data_q;
    logic [PIX_W-1:0] rd_data_d;

    // Storage array carries no reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank][wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_bank][rd_addr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ate_block_reorder.sv
// Raster-to-8x8-block reorder: ping-pong banks of BLK image rows, each
// block-row re-emitted as one gap-free burst with block/frame markers.
module ate_block_reorder
    import ate_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic [PIX_W-1:0] in_pix,
    output logic             in_ready,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_data,
    output logic             blk_last,
    output logic             frame_start
);

    // Write side
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        full_q, full_d;
    logic              in_ready_q, in_ready_d;

    // Read side
    rd_state_e         state_q, state_d;
    logic              rd_bank_q, rd_bank_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [RC_W-1:0]   r_q, r_d;
    logic [RC_W-1:0]   c_q, c_d;
    logic [BROW_W-1:0] brow_q, brow_d;

    logic              pix_valid_q, pix_valid_d;
    logic              blk_last_q, blk_last_d;
    logic              frame_start_q, frame_start_d;

    logic              accept;
    logic              wr_last;
    logic              issuing;
    logic              rd_last;
    logic [ADDR_W-1:0] rd_addr;

    assign accept  = in_valid & in_ready_q;
    assign wr_last = (wr_addr_q == ADDR_W'(BANK_WORDS - 1));
    assign issuing = (state_q == R_BURST);
    assign rd_last = issuing
                   && (blk_q == BLK_W'(BLKS_PER_ROW - 1))
                   && (r_q == RC_W'(BLK - 1))
                   && (c_q == RC_W'(BLK - 1));
    assign rd_addr = blk_addr(blk_q, r_q, c_q);

    // Bank fill and full-flag bookkeeping; in_ready tracks the post-edge flags.
    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        full_d    = full_q;
        if (accept) begin
            if (wr_last) begin
                wr_addr_d         = '0;
                wr_bank_d         = ~wr_bank_q;
                full_d[wr_bank_q] = 1'b1;
            end else begin
                wr_addr_d = wr_addr_q + ADDR_W'(1);
            end
        end
        if (rd_last) begin
            full_d[rd_bank_q] = 1'b0;
        end
        in_ready_d = ~full_d[wr_bank_d];
    end

    // Read FSM: walk blocks left to right, raster order within each block.
    always_comb begin
        state_d       = state_q;
        rd_bank_d     = rd_bank_q;
        blk_d         = blk_q;
        r_d           = r_q;
        c_d           = c_q;
        brow_d        = brow_q;
        pix_valid_d   = issuing;
        blk_last_d    = issuing && (r_q == RC_W'(BLK - 1)) && (c_q == RC_W'(BLK - 1));
        frame_start_d = issuing && (brow_q == '0) && (blk_q == '0)
                        && (r_q == '0) && (c_q == '0);

        case (state_q)
            R_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = R_BURST;
                    blk_d   = '0;
                    r_d     = '0;
                    c_d     = '0;
                end
            end
            R_BURST: begin
                if (rd_last) begin
                    rd_bank_d = ~rd_bank_q;
                    blk_d     = '0;
                    r_d       = '0;
                    c_d       = '0;
                    brow_d    = (brow_q == BROW_W'(BLK_ROWS - 1)) ? '0
                                                                  : brow_q + BROW_W'(1);
                    // Chain straight into the other bank when it is already waiting.
                    if (!full_q[~rd_bank_q]) begin
                        state_d = R_IDLE;
                    end
                end else if (c_q != RC_W'(BLK - 1)) begin
                    c_d = c_q + RC_W'(1);
                end else if (r_q != RC_W'(BLK - 1)) begin
                    c_d = '0;
                    r_d = r_q + RC_W'(1);
                end else begin
                    c_d   = '0;
                    r_d   = '0;
                    blk_d = blk_q + BLK_W'(1);
                end
            end
            default: begin
                state_d = R_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank_q     <= 1'b0;
            wr_addr_q     <= '0;
            full_q        <= '0;
            in_ready_q    <= 1'b1;
            state_q       <= R_IDLE;
            rd_bank_q     <= 1'b0;
            blk_q         <= '0;
            r_q           <= '0;
            c_q           <= '0;
            brow_q        <= '0;
            pix_valid_q   <= 1'b0;
            blk_last_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            wr_bank_q     <= wr_bank_d;
            wr_addr_q     <= wr_addr_d;
            full_q        <= full_d;
            in_ready_q    <= in_ready_d;
            state_q       <= state_d;
            rd_bank_q     <= rd_bank_d;
            blk_q         <= blk_d;
            r_q           <= r_d;
            c_q           <= c_d;
            brow_q        <= brow_d;
            pix_valid_q   <= pix_valid_d;
            blk_last_q    <= blk_last_d;
            frame_start_q <= frame_start_d;
        end
    end

    ate_bank_ram u_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (accept),
        .wr_bank (wr_bank_q),
        .wr_addr (wr_addr_q),
        .wr_data (in_pix),
        .rd_en   (issuing),
        .rd_bank (rd_bank_q),
        .rd_addr (rd_addr),
        .rd_data (pix_data)
    );

    assign in_ready    = in_ready_q;
    assign pix_valid   = pix_valid_q;
    assign blk_last    = blk_last_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ate_block_reorder.sv
// Directed/randomized bench for ate_block_reorder against a block-order
// scoreboard built from accepted raster pixels.
module tb_ate_block_reorder;

    localparam int W      = 48;
    localparam int B      = 8;
    localparam int ROWPIX = W * B;      // pixels per block-row
    localparam int NBROW  = 32 / B;     // block-rows per frame
    localparam int FRAME  = W * 32;

    typedef struct packed {
        logic [7:0] pix;
        logic       last;
        logic       fs;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic [7:0] in_pix;
    logic       in_ready;
    logic       pix_valid;
    logic [7:0] pix_data;
    logic       blk_last;
    logic       frame_start;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_acc = 0;
    int   last_wr_cyc = -1;
    int   first_val_cyc = -1;
    int   run = 0;
    int   wr_cnt = 0;
    int   brow = 0;
    logic [7:0] rowbuf [ROWPIX];
    obs_t exp_q [$];
    obs_t log_q [$];
    int   runs [$];

    ate_block_reorder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_pix      (in_pix),
        .in_ready    (in_ready),
        .pix_valid   (pix_valid),
        .pix_data    (pix_data),
        .blk_last    (blk_last),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a completed block-row is emitted block by block, raster inside a block.
    task automatic model_accept(input logic [7:0] p);
        obs_t e;
        rowbuf[wr_cnt] = p;
        wr_cnt++;
        if (wr_cnt == ROWPIX) begin
            for (int b = 0; b < W / B; b++)
                for (int r = 0; r < B; r++)
                    for (int c = 0; c < B; c++) begin
                        e.pix  = rowbuf[r * W + b * B + c];
                        e.last = (r == B - 1) && (c == B - 1);
                        e.fs   = (brow == 0) && (b == 0) && (r == 0) && (c == 0);
                        exp_q.push_back(e);
                    end
            wr_cnt = 0;
            brow   = (brow + 1) % NBROW;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        log_q.delete();
        runs.delete();
        wr_cnt = 0;
        brow   = 0;
        run    = 0;
        n_acc  = 0;
    endtask

    task automatic sample();
        obs_t o;
        o = '{pix: pix_data, last: blk_last, fs: frame_start};
        if (pix_valid === 1'b1) begin
            if (first_val_cyc < 0) first_val_cyc = cyc;
            run++;
            log_q.push_back(o);
            chk("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("out_pixel", 32'(o), 32'(exp_q.pop_front()));
        end else begin
            if (run > 0) runs.push_back(run);
            run = 0;
            chk("idle_flags", {30'd0, blk_last, frame_start}, 32'd0);
        end
    endtask

    task automatic step(output logic acc);
        acc = in_valid && in_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (acc) begin
            model_accept(in_pix);
            n_acc++;
            if (n_acc == ROWPIX && last_wr_cyc < 0) last_wr_cyc = cyc;
        end
        sample();
    endtask

    task automatic feed(input int first, input int n, input int pct, input bit rnd);
        logic       acc;
        int         sent = 0;
        int         guard = 0;
        logic [7:0] cur;
        cur = rnd ? 8'($urandom) : 8'(first);
        while (sent < n && guard < 20000) begin
            in_valid = (int'($urandom_range(99)) < pct);
            in_pix   = cur;
            step(acc);
            guard++;
            if (acc) begin
                sent++;
                cur = rnd ? 8'($urandom) : 8'(first + sent);
            end
        end
        in_valid = 1'b0;
        chk("feed_done", 32'(sent), 32'(n));
    endtask

    task automatic drain();
        logic acc;
        int   guard = 0;
        in_valid = 1'b0;
        while ((exp_q.size() != 0 || pix_valid) && guard < 4000) begin
            step(acc);
            guard++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic acc;
        int   fs_cnt;
        int   guard;
        int   sent;

        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_pix   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pix_data", 32'(pix_data), 32'd0);
        chk("rst_blk_last", 32'(blk_last), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        reset_n = 1'b1;
        step(acc);

        // Continuous ramp frame: latency, no-gap double burst, one-cycle stall at word 768.
        model_reset();
        feed(0, 2 * ROWPIX, 100, 1'b0);
        chk("t3_ready_low", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_pix   = 8'(2 * ROWPIX);
        step(acc);
        chk("t3_stall_taken", 32'(acc), 32'd0);
        chk("t3_ready_back", 32'(in_ready), 32'd1);
        feed(2 * ROWPIX, FRAME - 2 * ROWPIX, 100, 1'b0);
        drain();
        chk("t1_latency", 32'(first_val_cyc - last_wr_cyc), 32'd2);
        chk("t1_out_count", 32'(log_q.size()), 32'(FRAME));
        for (int i = 0; i < 8; i++) chk("t1_first8", 32'(log_q[i].pix), 32'(i));
        chk("t1_pix8", 32'(log_q[8].pix), 32'd48);
        chk("t1_pix63", {23'd0, log_q[63].pix, log_q[63].last}, {23'd0, 8'h57, 1'b1});
        chk("t1_pix62_last", 32'(log_q[62].last), 32'd0);
        chk("t2_first_run", 32'(runs.size() > 0 ? runs[0] : 0), 32'(2 * ROWPIX));
        fs_cnt = 0;
        foreach (log_q[i]) if (log_q[i].fs) fs_cnt++;
        chk("t2_fs_count", 32'(fs_cnt), 32'd1);
        chk("t2_fs_at0", 32'(log_q[0].fs), 32'd1);

        // 50% input valid: outputs only in whole block-row bursts.
        model_reset();
        feed(0, FRAME, 50, 1'b0);
        drain();
        chk("t4_out_count", 32'(log_q.size()), 32'(FRAME));
        foreach (runs[i]) chk("t4_run_len", 32'(runs[i] % ROWPIX), 32'd0);

        // Two random-data frames back to back: frame_start at 0 and FRAME.
        model_reset();
        feed(0, 2 * FRAME, 100, 1'b1);
        drain();
        chk("t6_out_count", 32'(log_q.size()), 32'(2 * FRAME));
        fs_cnt = 0;
        foreach (log_q[i]) if (log_q[i].fs) fs_cnt++;
        chk("t6_fs_count", 32'(fs_cnt), 32'd2);
        chk("t6_fs_second", 32'(log_q[FRAME].fs), 32'd1);

        // Reset in the middle of the first burst, then a fresh ramp frame.
        model_reset();
        in_valid = 1'b1;
        sent     = 0;
        guard    = 0;
        while (log_q.size() < 101 && guard < 5000) begin
            in_pix = 8'(sent);
            step(acc);
            if (acc) sent++;
            guard++;
        end
        chk("t5_reached_100", 32'(log_q.size()), 32'd101);
        chk("t5_mid_burst", 32'(pix_valid), 32'd1);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        chk("t5_rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("t5_rst_pix_data", 32'(pix_data), 32'd0);
        chk("t5_rst_flags", {30'd0, blk_last, frame_start}, 32'd0);
        chk("t5_rst_in_ready", 32'(in_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        feed(0, FRAME, 100, 1'b0);
        drain();
        chk("t5_out_count", 32'(log_q.size()), 32'(FRAME));
        chk("t5_first", {23'd0, log_q[0].pix, log_q[0].fs}, {23'd0, 8'd0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
